// File: rtl/dmac_multi_channel_ctrl_if.sv
// dmac_multi_channel_ctrl_if: command, buffer-level, burst-engine and status signals of the multi-channel DMA controller
interface dmac_multi_channel_ctrl_if #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 32,
   parameter int CHANNEL_COUNT = 4,
   parameter int MAX_BURST_LEN = 16
);
   localparam int OFS_WD = $clog2(DATA_WD / 8);
   localparam int CH_WD = $clog2(CHANNEL_COUNT);
   localparam int FL_WD = $clog2(MAX_BURST_LEN) + 1;
   logic cmd_valid, cmd_ready;
   logic [CH_WD-1:0] cmd_channel;
   logic [ADDR_WD-1:0] cmd_src_addr, cmd_dst_addr, cmd_len;
   logic [1:0] cmd_burst;
   logic [2:0] cmd_size;
   logic [CHANNEL_COUNT*FL_WD-1:0] buf_fill_level;
   logic rd_req_valid, rd_req_ack, rd_req_done, rd_resp_valid;
   logic [CH_WD-1:0] rd_req_channel, rd_resp_channel;
   logic [ADDR_WD-1:0] rd_req_addr, rd_req_length, rd_req_next_addr, rd_req_next_length;
   logic [1:0] rd_req_burst;
   logic [2:0] rd_req_size;
   logic wr_req_valid, wr_req_ack, wr_req_done;
   logic [CH_WD-1:0] wr_req_channel;
   logic [ADDR_WD-1:0] wr_req_addr, wr_req_length, wr_req_next_addr, wr_req_next_length;
   logic [1:0] wr_req_burst;
   logic [2:0] wr_req_size;
   logic [OFS_WD-1:0] wr_req_data_offset;
   logic [CHANNEL_COUNT-1:0] ch_busy, ch_done;
   modport master (
      input cmd_valid, cmd_channel, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size, buf_fill_level,
      input rd_req_ack, rd_req_next_addr, rd_req_next_length, rd_req_done, rd_resp_valid, rd_resp_channel,
      input wr_req_ack, wr_req_next_addr, wr_req_next_length, wr_req_done,
      output cmd_ready, rd_req_valid, rd_req_channel, rd_req_addr, rd_req_length, rd_req_burst, rd_req_size,
      output wr_req_valid, wr_req_channel, wr_req_addr, wr_req_length, wr_req_burst, wr_req_size, wr_req_data_offset,
      output ch_busy, ch_done
   );
   modport slave (
      output cmd_valid, cmd_channel, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_burst, cmd_size, buf_fill_level,
      output rd_req_ack, rd_req_next_addr, rd_req_next_length, rd_req_done, rd_resp_valid, rd_resp_channel,
      output wr_req_ack, wr_req_next_addr, wr_req_next_length, wr_req_done,
      input cmd_ready, rd_req_valid, rd_req_channel, rd_req_addr, rd_req_length, rd_req_burst, rd_req_size,
      input wr_req_valid, wr_req_channel, wr_req_addr, wr_req_length, wr_req_burst, wr_req_size, wr_req_data_offset,
      input ch_busy, ch_done
   );
endinterface

// File: rtl/dmac_multi_channel_ctrl.sv
// dmac_multi_channel_ctrl: per-channel DMA transfer contexts round-robin arbitrated onto shared read and write burst engines
module dmac_multi_channel_ctrl #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 32,
   parameter int CHANNEL_COUNT = 4,
   parameter int MAX_BURST_LEN = 16,
   parameter int RD_MAX_OUTSTANDING = 8
) (
   input logic clk,
   input logic rst,
   dmac_multi_channel_ctrl_if.master bus
);
   localparam int OFS_WD = $clog2(DATA_WD / 8);
   localparam int CH_WD = $clog2(CHANNEL_COUNT);
   localparam int FL_WD = $clog2(MAX_BURST_LEN) + 1;
   localparam int OC_WD = $clog2(RD_MAX_OUTSTANDING + 1);
   localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
   logic [0:0] st [CHANNEL_COUNT];
   logic [ADDR_WD-1:0] rd_ptr [CHANNEL_COUNT], rd_len [CHANNEL_COUNT], wr_ptr [CHANNEL_COUNT], wr_len [CHANNEL_COUNT];
   logic [OFS_WD-1:0] ofs [CHANNEL_COUNT];
   logic [1:0] burst [CHANNEL_COUNT];
   logic [2:0] size [CHANNEL_COUNT];
   logic [OC_WD-1:0] oc [CHANNEL_COUNT];
   logic [CHANNEL_COUNT-1:0] busy, rd_dn, wr_dn, rd_el, wr_el, done_q;
   logic rd_v, wr_v, accept;
   logic [CH_WD-1:0] rd_sel, wr_sel, rd_rr, wr_rr;
   logic [CH_WD:0] rd_pick, wr_pick;
   // scan downwards so the first eligible channel at or after start wins
   function automatic logic [CH_WD:0] pick(input logic [CHANNEL_COUNT-1:0] el, input logic [CH_WD-1:0] start);
      int j;
      pick = '0;
      for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
         j = (int'(start) + k) % CHANNEL_COUNT;
         if (el[j]) pick = {1'b1, CH_WD'(j)};
      end
   endfunction
   function automatic logic [CH_WD-1:0] nxt(input logic [CH_WD-1:0] c);
      return CH_WD'((int'(c) + 1) % CHANNEL_COUNT);
   endfunction
   always_comb begin
      for (int i = 0; i < CHANNEL_COUNT; i++) busy[i] = st[i] == ACTIVE;
   end
   always_comb begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         rd_el[i] = st[i] == ACTIVE && !rd_dn[i] && oc[i] < OC_WD'(RD_MAX_OUTSTANDING);
         wr_el[i] = st[i] == ACTIVE && !wr_dn[i] &&
                    (bus.buf_fill_level[i*FL_WD +: FL_WD] >= FL_WD'(MAX_BURST_LEN) || (rd_dn[i] && oc[i] == '0));
      end
   end
   assign rd_pick = pick(rd_el, rd_rr);
   assign wr_pick = pick(wr_el, wr_rr);
   assign accept = bus.cmd_valid && bus.cmd_ready;
   assign bus.cmd_ready = !busy[bus.cmd_channel];
   assign bus.ch_busy = busy;
   assign bus.ch_done = done_q;
   assign bus.rd_req_valid = rd_v;
   assign bus.rd_req_channel = rd_sel;
   assign bus.rd_req_addr = rd_ptr[rd_sel];
   assign bus.rd_req_length = rd_len[rd_sel];
   assign bus.rd_req_burst = burst[rd_sel];
   assign bus.rd_req_size = size[rd_sel];
   assign bus.wr_req_valid = wr_v;
   assign bus.wr_req_channel = wr_sel;
   assign bus.wr_req_addr = wr_ptr[wr_sel];
   assign bus.wr_req_length = wr_len[wr_sel];
   assign bus.wr_req_burst = burst[wr_sel];
   assign bus.wr_req_size = size[wr_sel];
   assign bus.wr_req_data_offset = ofs[wr_sel];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNEL_COUNT; i++) begin
            st[i] <= IDLE;
            rd_ptr[i] <= '0;
            rd_len[i] <= '0;
            wr_ptr[i] <= '0;
            wr_len[i] <= '0;
            ofs[i] <= '0;
            burst[i] <= '0;
            size[i] <= '0;
            oc[i] <= '0;
         end
         rd_dn <= '0;
         wr_dn <= '0;
         done_q <= '0;
         rd_v <= 1'b0;
         wr_v <= 1'b0;
         rd_sel <= '0;
         wr_sel <= '0;
         rd_rr <= '0;
         wr_rr <= '0;
      end else begin
         done_q <= '0;
         // an ack and a response to the same channel cancel; a stray response never underflows
         for (int i = 0; i < CHANNEL_COUNT; i++)
            oc[i] <= (rd_v && bus.rd_req_ack && rd_sel == CH_WD'(i) && !(bus.rd_resp_valid && bus.rd_resp_channel == CH_WD'(i))) ? oc[i] + 1'b1 :
                     (bus.rd_resp_valid && bus.rd_resp_channel == CH_WD'(i) && !(rd_v && bus.rd_req_ack && rd_sel == CH_WD'(i)) && oc[i] != '0) ? oc[i] - 1'b1 : oc[i];
         if (!rd_v) begin
            rd_v <= rd_pick[CH_WD];
            if (rd_pick[CH_WD]) rd_sel <= rd_pick[CH_WD-1:0];
         end else if (bus.rd_req_ack) begin
            rd_ptr[rd_sel] <= bus.rd_req_next_addr;
            rd_len[rd_sel] <= bus.rd_req_next_length;
            if (bus.rd_req_done) rd_dn[rd_sel] <= 1'b1;
            rd_rr <= nxt(rd_sel);
            rd_v <= 1'b0;
         end
         if (!wr_v) begin
            wr_v <= wr_pick[CH_WD];
            if (wr_pick[CH_WD]) wr_sel <= wr_pick[CH_WD-1:0];
         end else if (bus.wr_req_ack) begin
            wr_ptr[wr_sel] <= bus.wr_req_next_addr;
            wr_len[wr_sel] <= bus.wr_req_next_length;
            if (bus.wr_req_done) begin
               wr_dn[wr_sel] <= 1'b1;
               st[wr_sel] <= IDLE;
               done_q[wr_sel] <= 1'b1;
            end
            wr_rr <= nxt(wr_sel);
            wr_v <= 1'b0;
         end
         if (accept) begin
            rd_ptr[bus.cmd_channel] <= bus.cmd_src_addr;
            wr_ptr[bus.cmd_channel] <= bus.cmd_dst_addr;
            rd_len[bus.cmd_channel] <= bus.cmd_len;
            wr_len[bus.cmd_channel] <= bus.cmd_len;
            ofs[bus.cmd_channel] <= bus.cmd_src_addr[OFS_WD-1:0];
            burst[bus.cmd_channel] <= bus.cmd_burst;
            size[bus.cmd_channel] <= bus.cmd_size;
            rd_dn[bus.cmd_channel] <= 1'b0;
            wr_dn[bus.cmd_channel] <= 1'b0;
            if (bus.cmd_len == '0) done_q[bus.cmd_channel] <= 1'b1;
            else st[bus.cmd_channel] <= ACTIVE;
         end
      end
   end
endmodule

// File: tb/tb_dmac_multi_channel_ctrl.sv
// tb_dmac_multi_channel_ctrl: directed scenarios checked against a transaction-level channel/arbiter model plus literal expectations
module tb_dmac_multi_channel_ctrl;
   localparam int AW = 32, DW = 32, NC = 4, MB = 16, MO = 8, CW = 2, FW = 5;
   logic clk = 1'b0, rst = 1'b1;
   int n_vec = 0, n_err = 0, cyc = 0;
   logic rd_auto = 1'b0, wr_auto = 1'b0, rd_dflag = 1'b0, wr_dflag = 1'b0;
   logic [FW-1:0] fill [NC];
   int rd_log [$], wr_log [$], rd_cyc [$];
   logic [AW-1:0] rd_alog [$], wr_alog [$];
   int done_cnt [NC];
   bit m_busy [NC], m_rdd [NC], m_wrd [NC], m_done [NC];
   int m_oc [NC];
   logic [AW-1:0] m_rp [NC], m_rl [NC], m_wp [NC], m_wl [NC], m_src [NC];
   logic [1:0] m_bu [NC];
   logic [2:0] m_sz [NC];
   int rd_rr, wr_rr, rd_c, wr_c;
   bit rd_g, wr_g;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dmac_multi_channel_ctrl_if #(.ADDR_WD(AW), .DATA_WD(DW), .CHANNEL_COUNT(NC), .MAX_BURST_LEN(MB)) bus ();
   dmac_multi_channel_ctrl #(.ADDR_WD(AW), .DATA_WD(DW), .CHANNEL_COUNT(NC), .MAX_BURST_LEN(MB), .RD_MAX_OUTSTANDING(MO))
      dut (.clk(clk), .rst(rst), .bus(bus));

   // burst engines: each burst moves 64 bytes
   assign bus.rd_req_ack = rd_auto & bus.rd_req_valid;
   assign bus.rd_req_done = rd_dflag;
   assign bus.rd_req_next_addr = bus.rd_req_addr + 32'd64;
   assign bus.rd_req_next_length = bus.rd_req_length > 32'd64 ? bus.rd_req_length - 32'd64 : '0;
   assign bus.wr_req_ack = wr_auto & bus.wr_req_valid;
   assign bus.wr_req_done = wr_dflag;
   assign bus.wr_req_next_addr = bus.wr_req_addr + 32'd64;
   assign bus.wr_req_next_length = bus.wr_req_length > 32'd64 ? bus.wr_req_length - 32'd64 : '0;
   always_comb begin
      for (int i = 0; i < NC; i++) bus.buf_fill_level[i*FW +: FW] = fill[i];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NC; i++) begin
         m_busy[i] = 0; m_rdd[i] = 0; m_wrd[i] = 0; m_done[i] = 0; m_oc[i] = 0;
         m_rp[i] = '0; m_rl[i] = '0; m_wp[i] = '0; m_wl[i] = '0; m_src[i] = '0; m_bu[i] = '0; m_sz[i] = '0;
      end
      rd_rr = 0; wr_rr = 0; rd_c = 0; wr_c = 0; rd_g = 0; wr_g = 0;
   endtask

   initial m_reset();

   // model: outputs for this cycle are checked, then the model advances as the next clock edge will
   always @(negedge clk) begin : model
      logic [NC-1:0] eb, ed;
      bit re [NC], we [NC], nd [NC];
      bit acc, rack, wack, fnd, inc, dec;
      int c;
      if (rst) m_reset();
      for (int i = 0; i < NC; i++) begin
         eb[i] = m_busy[i];
         ed[i] = m_done[i];
      end
      chk("ch_busy", bus.ch_busy, eb);
      chk("ch_done", bus.ch_done, ed);
      chk("cmd_ready", bus.cmd_ready, !m_busy[bus.cmd_channel]);
      chk("rd_valid", bus.rd_req_valid, rd_g);
      if (rd_g) begin
         chk("rd_channel", bus.rd_req_channel, rd_c);
         chk("rd_addr", bus.rd_req_addr, m_rp[rd_c]);
         chk("rd_length", bus.rd_req_length, m_rl[rd_c]);
         chk("rd_burst", bus.rd_req_burst, m_bu[rd_c]);
         chk("rd_size", bus.rd_req_size, m_sz[rd_c]);
      end
      chk("wr_valid", bus.wr_req_valid, wr_g);
      if (wr_g) begin
         chk("wr_channel", bus.wr_req_channel, wr_c);
         chk("wr_addr", bus.wr_req_addr, m_wp[wr_c]);
         chk("wr_length", bus.wr_req_length, m_wl[wr_c]);
         chk("wr_burst", bus.wr_req_burst, m_bu[wr_c]);
         chk("wr_size", bus.wr_req_size, m_sz[wr_c]);
         chk("wr_offset", bus.wr_req_data_offset, m_src[wr_c][1:0]);
      end
      if (!rst) begin
         if (bus.rd_req_valid && bus.rd_req_ack) begin
            rd_log.push_back(int'(bus.rd_req_channel));
            rd_alog.push_back(bus.rd_req_addr);
            rd_cyc.push_back(cyc);
         end
         if (bus.wr_req_valid && bus.wr_req_ack) begin
            wr_log.push_back(int'(bus.wr_req_channel));
            wr_alog.push_back(bus.wr_req_addr);
         end
         for (int i = 0; i < NC; i++) if (bus.ch_done[i]) done_cnt[i]++;
         for (int i = 0; i < NC; i++) begin
            re[i] = m_busy[i] && !m_rdd[i] && m_oc[i] < MO;
            we[i] = m_busy[i] && !m_wrd[i] && (fill[i] >= MB || (m_rdd[i] && m_oc[i] == 0));
            nd[i] = 0;
         end
         acc = bus.cmd_valid && !m_busy[bus.cmd_channel];
         rack = rd_g && bus.rd_req_ack;
         wack = wr_g && bus.wr_req_ack;
         for (int i = 0; i < NC; i++) begin
            inc = rack && rd_c == i;
            dec = bus.rd_resp_valid && int'(bus.rd_resp_channel) == i;
            if (inc && !dec) m_oc[i]++;
            else if (dec && !inc && m_oc[i] > 0) m_oc[i]--;
         end
         if (!rd_g) begin
            fnd = 0;
            for (int k = 0; k < NC; k++) begin
               c = (rd_rr + k) % NC;
               if (!fnd && re[c]) begin fnd = 1; rd_g = 1; rd_c = c; end
            end
         end else if (rack) begin
            m_rp[rd_c] = bus.rd_req_next_addr;
            m_rl[rd_c] = bus.rd_req_next_length;
            if (bus.rd_req_done) m_rdd[rd_c] = 1;
            rd_rr = (rd_c + 1) % NC;
            rd_g = 0;
         end
         if (!wr_g) begin
            fnd = 0;
            for (int k = 0; k < NC; k++) begin
               c = (wr_rr + k) % NC;
               if (!fnd && we[c]) begin fnd = 1; wr_g = 1; wr_c = c; end
            end
         end else if (wack) begin
            m_wp[wr_c] = bus.wr_req_next_addr;
            m_wl[wr_c] = bus.wr_req_next_length;
            if (bus.wr_req_done) begin m_wrd[wr_c] = 1; m_busy[wr_c] = 0; nd[wr_c] = 1; end
            wr_rr = (wr_c + 1) % NC;
            wr_g = 0;
         end
         if (acc) begin
            c = int'(bus.cmd_channel);
            m_rp[c] = bus.cmd_src_addr; m_wp[c] = bus.cmd_dst_addr;
            m_rl[c] = bus.cmd_len; m_wl[c] = bus.cmd_len; m_src[c] = bus.cmd_src_addr;
            m_bu[c] = bus.cmd_burst; m_sz[c] = bus.cmd_size;
            m_rdd[c] = 0; m_wrd[c] = 0;
            if (bus.cmd_len == 0) nd[c] = 1;
            else m_busy[c] = 1;
         end
         for (int i = 0; i < NC; i++) m_done[i] = nd[i];
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
      bus.cmd_valid = 1'b1;
      bus.cmd_channel = CW'(ch);
      bus.cmd_src_addr = s;
      bus.cmd_dst_addr = d;
      bus.cmd_len = l;
      tick(1);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic clr();
      rd_log.delete(); wr_log.delete(); rd_cyc.delete(); rd_alog.delete(); wr_alog.delete();
      for (int i = 0; i < NC; i++) done_cnt[i] = 0;
   endtask

   task automatic do_reset();
      rd_auto = 0; wr_auto = 0; rd_dflag = 0; wr_dflag = 0;
      for (int i = 0; i < NC; i++) fill[i] = '0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      clr();
   endtask

   task automatic wait_rd(input int n);
      int b = 0;
      while (rd_log.size() < n && b < 200) begin
         tick(1);
         b++;
      end
      chk("rd_ack_budget", rd_log.size() >= n, 1'b1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_channel = '0; bus.cmd_src_addr = '0; bus.cmd_dst_addr = '0; bus.cmd_len = '0;
      bus.cmd_burst = 2'b01; bus.cmd_size = 3'd2; bus.rd_resp_valid = 1'b0; bus.rd_resp_channel = '0;
      do_reset();
      chk("rst_busy", bus.ch_busy, 4'h0);
      chk("rst_done", bus.ch_done, 4'h0);
      chk("rst_rd_valid", bus.rd_req_valid, 1'b0);
      chk("rst_wr_valid", bus.wr_req_valid, 1'b0);
      chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

      // single transfer on ch1
      rd_auto = 1; wr_auto = 1; rd_dflag = 1; wr_dflag = 1;
      send(1, 32'h1000, 32'h2000, 32'd64);
      fill[1] = 5'd16;
      tick(8);
      chk("t1_rd_count", rd_log.size(), 1);
      chk("t1_rd_ch", rd_log[0], 1);
      chk("t1_rd_addr", rd_alog[0], 32'h1000);
      chk("t1_wr_count", wr_log.size(), 1);
      chk("t1_wr_addr", wr_alog[0], 32'h2000);
      chk("t1_done", done_cnt[1], 1);
      chk("t1_busy", bus.ch_busy[1], 1'b0);

      // fairness across all four channels
      clr();
      rd_auto = 0; wr_auto = 0; rd_dflag = 0; wr_dflag = 0; fill[1] = '0;
      for (int i = 0; i < NC; i++) send(i, 32'h8000 + 32'(i) * 32'h1000, 32'h9000, 32'd1024);
      rd_auto = 1;
      wait_rd(5);
      rd_auto = 0;
      for (int i = 0; i < 5; i++) chk("t2_order", rd_log[i], i % NC);
      for (int i = 1; i < 5; i++) chk("t2_spacing", rd_cyc[i] - rd_cyc[i-1], 2);

      // outstanding limit on ch2
      do_reset();
      rd_auto = 1;
      send(2, 32'h4000, 32'h5000, 32'd4096);
      tick(30);
      chk("t3_acks", rd_log.size(), 8);
      chk("t3_stall", bus.rd_req_valid, 1'b0);
      bus.rd_resp_channel = 2'd2; bus.rd_resp_valid = 1'b1;
      tick(1);
      bus.rd_resp_valid = 1'b0;
      tick(6);
      chk("t3_ninth", rd_log.size(), 9);

      // stray response at zero, then simultaneous ack and response at three
      do_reset();
      send(0, 32'h100, 32'h200, 32'h10000);
      tick(1);
      bus.rd_resp_channel = 2'd0; bus.rd_resp_valid = 1'b1;
      tick(1);
      bus.rd_resp_valid = 1'b0;
      rd_auto = 1;
      wait_rd(3);
      rd_auto = 0;
      tick(2);
      chk("t4_pending", bus.rd_req_valid, 1'b1);
      rd_auto = 1; bus.rd_resp_valid = 1'b1;
      tick(1);
      rd_auto = 0; bus.rd_resp_valid = 1'b0;
      chk("t4_four", rd_log.size(), 4);
      rd_auto = 1;
      tick(30);
      chk("t4_total", rd_log.size(), 9);
      chk("t4_stall", bus.rd_req_valid, 1'b0);

      // write gate on ch1
      do_reset();
      fill[1] = 5'd15;
      send(1, 32'h3005, 32'h4000, 32'd256);
      tick(5);
      chk("t5_gate15", bus.wr_req_valid, 1'b0);
      fill[1] = 5'd16;
      tick(3);
      chk("t5_gate16", bus.wr_req_valid, 1'b1);
      chk("t5_wr_ch", bus.wr_req_channel, 2'd1);
      chk("t5_offset", bus.wr_req_data_offset, 2'd1);
      wr_auto = 1;
      tick(1);
      wr_auto = 0; fill[1] = 5'd4;
      chk("t5_wr_one", wr_log.size(), 1);
      rd_dflag = 1; rd_auto = 1;
      tick(1);
      rd_auto = 0;
      tick(3);
      chk("t5_wait_resp", bus.wr_req_valid, 1'b0);
      bus.rd_resp_channel = 2'd1; bus.rd_resp_valid = 1'b1;
      tick(1);
      bus.rd_resp_valid = 1'b0;
      tick(3);
      chk("t5_drain", bus.wr_req_valid, 1'b1);
      wr_dflag = 1; wr_auto = 1;
      tick(4);
      chk("t5_done", done_cnt[1], 1);
      chk("t5_busy", bus.ch_busy, 4'h0);
      chk("t5_wr_two", wr_log.size(), 2);

      // zero length, busy refusal, reset mid-transfer
      clr();
      wr_auto = 0; wr_dflag = 0; rd_dflag = 0;
      send(3, 32'h0, 32'h0, 32'd0);
      chk("t6_zero_pulse", bus.ch_done[3], 1'b1);
      tick(4);
      chk("t6_zero_count", done_cnt[3], 1);
      chk("t6_zero_rd", rd_log.size(), 0);
      chk("t6_zero_busy", bus.ch_busy, 4'h0);
      send(2, 32'h500, 32'h600, 32'd256);
      bus.cmd_channel = 2'd2;
      #1;
      chk("t6_busy_ready", bus.cmd_ready, 1'b0);
      bus.cmd_channel = 2'd0;
      #1;
      chk("t6_idle_ready", bus.cmd_ready, 1'b1);
      bus.cmd_channel = 2'd2; bus.cmd_len = '0; bus.cmd_valid = 1'b1;
      tick(1);
      bus.cmd_valid = 1'b0;
      tick(2);
      chk("t6_refused", done_cnt[2], 0);
      rst = 1'b1;
      tick(1);
      chk("t6_rst_busy", bus.ch_busy, 4'h0);
      chk("t6_rst_rd", bus.rd_req_valid, 1'b0);
      rst = 1'b0;
      tick(3);
      chk("t6_rst_nodone", done_cnt[2], 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
